// File: rtl/norm_pkg.sv
// Shared defaults and types for the norm_pipe accumulator renormaliser.
package norm_pkg;

   localparam int DEF_MANT_W  = 16;
   localparam int DEF_EXP_W   = 8;
   localparam int DEF_EXP_MAX = 2**DEF_EXP_W - 2;

   typedef logic [$clog2(DEF_MANT_W)-1:0] lz_t;

   typedef struct packed {
      logic [DEF_MANT_W-1:0] mant;
      logic [DEF_EXP_W-1:0]  exp;
      logic                  zero;
      logic                  inf;
   } norm_res_t;

endpackage

// File: rtl/norm_pipe_lzd.sv
// Leading-zero detector: count of zeros above the highest set bit; WIDTH when the field is all zero.
module norm_pipe_lzd #(
   parameter int WIDTH = 15,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] count
);

   // NOTE: count gets a value before the loop, so every path assigns it and no latch is inferred.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/norm_pipe.sv
// Two-stage valid/ready renormaliser with flush-to-zero and saturate-to-infinity.
// Define NORM_ROUND_EN to round the right-shift case to nearest, ties to even.
module norm_pipe
   import norm_pkg::*;
#(
   parameter int MANT_W  = DEF_MANT_W,
   parameter int EXP_W   = DEF_EXP_W,
   parameter int EXP_MAX = 2**EXP_W - 2,
   parameter int TAG_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W:0]   in_mant,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mant,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_zero,
   output logic              out_inf,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int LZ_W = $clog2(MANT_W);

   logic [MANT_W-1:0] u;
   logic [LZ_W-1:0]   lz;
   logic              s2_en;

   logic              s1_valid;
   logic [MANT_W:0]   s1_mant;
   logic [EXP_W-1:0]  s1_exp;
   logic [TAG_W-1:0]  s1_tag;
   logic              s1_u_msb;
   logic [LZ_W-1:0]   s1_lz;
   logic              s1_zero_mant;
   logic              s1_min;

   logic              right;
   logic [MANT_W-1:0] m_trunc;
   logic [MANT_W-1:0] m_right;
   logic [MANT_W-1:0] m_left;
   logic              sel_zero;
   logic              sel_inf;
   logic [MANT_W-1:0] nxt_mant;
   logic [EXP_W-1:0]  nxt_exp;
   logic              nxt_zero;
   logic              nxt_inf;

   // Magnitude modulo 2^MANT_W: the most negative input wraps to 0 and is caught by s1_min.
   assign u = in_mant[MANT_W] ? (~in_mant[MANT_W-1:0] + MANT_W'(1)) : in_mant[MANT_W-1:0];

   norm_pipe_lzd #(
      .WIDTH (MANT_W - 1),
      .CNT_W (LZ_W)
   ) u_lzd (
      .value (u[MANT_W-2:0]),
      .count (lz)
   );

   assign s2_en    = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_en;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_mant      <= '0;
         s1_exp       <= '0;
         s1_tag       <= '0;
         s1_u_msb     <= 1'b0;
         s1_lz        <= '0;
         s1_zero_mant <= 1'b0;
         s1_min       <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mant      <= in_mant;
            s1_exp       <= in_exp;
            s1_tag       <= in_tag;
            s1_u_msb     <= u[MANT_W-1];
            s1_lz        <= lz;
            s1_zero_mant <= (in_mant == '0);
            s1_min       <= (in_mant == {1'b1, {MANT_W{1'b0}}});
         end
      end
   end

   always_comb begin
      right   = s1_u_msb || s1_min;
      m_trunc = s1_mant[MANT_W:1];
`ifdef NORM_ROUND_EN
      m_right = m_trunc + MANT_W'(s1_mant[0] & m_trunc[0]);
      if (!s1_mant[MANT_W] && m_right[MANT_W-1])
         m_right = {1'b0, {(MANT_W-1){1'b1}}};
`else
      m_right = m_trunc;
`endif
      m_left   = s1_mant[MANT_W-1:0] << s1_lz;
      sel_inf  = right ? (s1_exp >= EXP_W'(EXP_MAX - 1)) : (s1_exp >= EXP_W'(EXP_MAX));
      sel_zero = s1_zero_mant || (!right && (s1_exp <= EXP_W'(s1_lz)));

      nxt_mant = right ? m_right : m_left;
      nxt_exp  = right ? (s1_exp + EXP_W'(1)) : (s1_exp - EXP_W'(s1_lz));
      nxt_zero = 1'b0;
      nxt_inf  = 1'b0;
      if (sel_zero) begin
         nxt_mant = '0;
         nxt_exp  = '0;
         nxt_zero = 1'b1;
      end else if (sel_inf) begin
         nxt_mant = '0;
         nxt_exp  = '1;
         nxt_inf  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_mant  <= '0;
         out_exp   <= '0;
         out_zero  <= 1'b0;
         out_inf   <= 1'b0;
         out_tag   <= '0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_mant <= nxt_mant;
            out_exp  <= nxt_exp;
            out_zero <= nxt_zero;
            out_inf  <= nxt_inf;
            out_tag  <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_norm_pipe.sv
// Self-checking bench for norm_pipe: directed limits, backpressure, mid-run reset and random traffic.
module tb_norm_pipe;
   import norm_pkg::*;

   localparam int MW = DEF_MANT_W;
   localparam int EW = DEF_EXP_W;
   localparam int TW = 4;
   localparam int ND = 16;

`ifdef NORM_ROUND_EN
   localparam logic [MW-1:0] RSH_MANT = 16'h4002;
`else
   localparam logic [MW-1:0] RSH_MANT = 16'h4001;
`endif

   typedef struct packed {
      norm_res_t       res;
      logic [TW-1:0]   tag;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [MW:0]   in_mant = '0;
   logic [EW-1:0] in_exp = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [MW-1:0] out_mant;
   logic [EW-1:0] out_exp;
   logic          out_zero;
   logic          out_inf;
   logic [TW-1:0] out_tag;

   sb_t       sb[$];
   norm_res_t drv_exp = '0;
   int        n_cmp = 0;
   int        n_bad = 0;
   logic      rand_ready = 1'b0;

   logic [MW:0]   dir_m [ND];
   logic [EW-1:0] dir_e [ND];
   norm_res_t     dir_r [ND];

   norm_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mant   (in_mant),
      .in_exp    (in_exp),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_zero  (out_zero),
      .out_inf   (out_inf),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic norm_res_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                    input logic z, input logic i);
      norm_res_t x;
      x.mant = m;
      x.exp  = e;
      x.zero = z;
      x.inf  = i;
      return x;
   endfunction

   // Integer reference model of the renormaliser.
   function automatic norm_res_t model(input logic [MW:0] mant, input logic [EW-1:0] e);
      int v, a, s, r, ei;
      norm_res_t x;
      x  = '0;
      v  = int'($signed(mant));
      a  = (v < 0) ? -v : v;
      ei = int'(e);
      if (v == 0) begin
         x.zero = 1'b1;
      end else if (a >= 32768) begin
         r = v >>> 1;
`ifdef NORM_ROUND_EN
         if (((v & 1) != 0) && ((r & 1) != 0)) r = r + 1;
         if (r > 32767) r = 32767;
`endif
         if (ei >= DEF_EXP_MAX - 1) begin
            x.exp = '1;
            x.inf = 1'b1;
         end else begin
            x.mant = 16'(r);
            x.exp  = 8'(ei + 1);
         end
      end else begin
         s = 0;
         while ((a << s) < 16384) s++;
         if (ei <= s) begin
            x.zero = 1'b1;
         end else if (ei >= DEF_EXP_MAX) begin
            x.exp = '1;
            x.inf = 1'b1;
         end else begin
            x.mant = 16'(v << s);
            x.exp  = 8'(ei - s);
         end
      end
      return x;
   endfunction

   always @(negedge clk) begin
      sb_t want;
      sb_t ent;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'(out_valid), 32'(0));
            end else begin
               want = sb.pop_front();
               check("out_tag",  32'(out_tag),  32'(want.tag));
               check("out_mant", 32'(out_mant), 32'(want.res.mant));
               check("out_exp",  32'(out_exp),  32'(want.res.exp));
               check("out_zero", 32'(out_zero), 32'(want.res.zero));
               check("out_inf",  32'(out_inf),  32'(want.res.inf));
            end
         end
         if (in_valid && in_ready) begin
            ent.res = drv_exp;
            ent.tag = in_tag;
            sb.push_back(ent);
         end
      end
   end

   task automatic send(input logic [MW:0] m, input logic [EW-1:0] e, input logic [TW-1:0] t,
                       input norm_res_t x);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_mant  = m;
      in_exp   = e;
      in_tag   = t;
      drv_exp  = x;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("send_timeout", 32'(in_ready), 32'(1));
            break;
         end
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_empty", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      int           acc;
      logic [31:0]  snap;
      logic [MW:0]  bp_m;
      logic [EW-1:0] bp_e;

      dir_m[0]  = 17'h04000; dir_e[0]  = 8'd100; dir_r[0]  = mk(16'h4000, 8'd100, 1'b0, 1'b0);
      dir_m[1]  = 17'h00001; dir_e[1]  = 8'd20;  dir_r[1]  = mk(16'h4000, 8'd6,   1'b0, 1'b0);
      dir_m[2]  = 17'h1FFFF; dir_e[2]  = 8'd20;  dir_r[2]  = mk(16'hC000, 8'd6,   1'b0, 1'b0);
      dir_m[3]  = 17'h08003; dir_e[3]  = 8'd100; dir_r[3]  = mk(RSH_MANT,  8'd101, 1'b0, 1'b0);
      dir_m[4]  = 17'h00001; dir_e[4]  = 8'd14;  dir_r[4]  = mk(16'h0000, 8'd0,   1'b1, 1'b0);
      dir_m[5]  = 17'h08000; dir_e[5]  = 8'd253; dir_r[5]  = mk(16'h0000, 8'hFF,  1'b0, 1'b1);
      dir_m[6]  = 17'h10000; dir_e[6]  = 8'd50;  dir_r[6]  = mk(16'h8000, 8'd51,  1'b0, 1'b0);
      dir_m[7]  = 17'h00000; dir_e[7]  = 8'd100; dir_r[7]  = mk(16'h0000, 8'd0,   1'b1, 1'b0);
      dir_m[8]  = 17'h00001; dir_e[8]  = 8'd15;  dir_r[8]  = mk(16'h4000, 8'd1,   1'b0, 1'b0);
      dir_m[9]  = 17'h04000; dir_e[9]  = 8'd254; dir_r[9]  = mk(16'h0000, 8'hFF,  1'b0, 1'b1);
      dir_m[10] = 17'h04000; dir_e[10] = 8'd253; dir_r[10] = mk(16'h4000, 8'd253, 1'b0, 1'b0);
      dir_m[11] = 17'h08000; dir_e[11] = 8'd252; dir_r[11] = mk(16'h4000, 8'd253, 1'b0, 1'b0);
      dir_m[12] = 17'h0FFFF; dir_e[12] = 8'd100; dir_r[12] = mk(16'h7FFF, 8'd101, 1'b0, 1'b0);
      dir_m[13] = 17'h08001; dir_e[13] = 8'd10;  dir_r[13] = mk(16'h4000, 8'd11,  1'b0, 1'b0);
      dir_m[14] = 17'h00000; dir_e[14] = 8'd255; dir_r[14] = mk(16'h0000, 8'd0,   1'b1, 1'b0);
      dir_m[15] = 17'h10000; dir_e[15] = 8'd253; dir_r[15] = mk(16'h0000, 8'hFF,  1'b0, 1'b1);

      // Reset state.
      #1;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_mant",  32'(out_mant),  32'(0));
      check("rst_out_exp",   32'(out_exp),   32'(0));
      check("rst_out_flags", 32'({out_zero, out_inf}), 32'(0));
      check("rst_out_tag",   32'(out_tag),   32'(0));
      check("rst_in_ready",  32'(in_ready),  32'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Two-cycle latency on the first sample.
      send(dir_m[0], dir_e[0], 4'd0, dir_r[0]);
      check("latency_s1", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
      check("latency_s2", 32'(out_valid), 32'(1));

      for (int i = 1; i < ND; i++)
         send(dir_m[i], dir_e[i], TW'(i), dir_r[i]);
      drain();

      // Backpressure: only two samples fit, then outputs hold.
      out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         bp_m     = 17'($urandom);
         bp_e     = 8'($urandom_range(20, 200));
         in_valid = 1'b1;
         in_mant  = bp_m;
         in_exp   = bp_e;
         in_tag   = TW'(acc + 1);
         drv_exp  = model(bp_m, bp_e);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      check("bp_accepted", 32'(acc), 32'(2));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_tag",  32'(out_tag), 32'(1));
      snap = 32'({out_valid, out_mant, out_exp, out_zero, out_inf, out_tag});
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold", 32'({out_valid, out_mant, out_exp, out_zero, out_inf, out_tag}), snap);

      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("bp_release_valid", 32'(out_valid), 32'(1));
         check("bp_release_tag",   32'(out_tag),   32'(k));
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
         if (acc < 4) begin
            bp_m    = 17'($urandom);
            bp_e    = 8'($urandom_range(20, 200));
            in_mant = bp_m;
            in_exp  = bp_e;
            in_tag  = TW'(acc + 1);
            drv_exp = model(bp_m, bp_e);
         end else begin
            in_valid = 1'b0;
         end
      end
      drain();

      // Reset with a full pipe drops everything at once.
      out_ready = 1'b0;
      send(17'h04000, 8'd90, 4'd9, model(17'h04000, 8'd90));
      send(17'h00123, 8'd90, 4'd10, model(17'h00123, 8'd90));
      @(posedge clk);
      #1;
      check("full_before_rst", 32'({out_valid, in_ready}), 32'(2'b10));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'(0));
      check("midrst_out_tag",   32'(out_tag),   32'(0));
      check("midrst_out_mant",  32'(out_mant),  32'(0));
      sb.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check("postrst_in_ready", 32'(in_ready), 32'(1));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("postrst_no_stale", 32'(out_valid), 32'(0));
      end
      @(posedge clk);
      #1;

      // Random traffic with random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bp_m = 17'($urandom);
         if (i % 3 == 0) bp_m = 17'($urandom_range(0, 300));
         if (i % 5 == 1) bp_m = 17'(-int'($urandom_range(0, 300)));
         bp_e = 8'($urandom_range(0, 255));
         send(bp_m, bp_e, TW'(i), model(bp_m, bp_e));
      end
      rand_ready = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
